// File: rtl/compact_queue.sv
// Circular queue behind the lane-compaction network: takes up to NUM_INPUT
// compacted entries per cycle and presents the oldest NUM_OUTPUT in order.
module compact_queue #(
  parameter int NUM_INPUT  = 8,
  parameter int INPUT_SIZE = 4,
  parameter int NUM_OUTPUT = 4,
  parameter int DEPTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [NUM_INPUT-1:0]                 in_vld,
  input  logic [NUM_INPUT*INPUT_SIZE-1:0]      in_data,
  output logic                                 in_rdy,
  output logic [NUM_OUTPUT-1:0]                out_vld,
  output logic [NUM_OUTPUT*INPUT_SIZE-1:0]     out_data,
  input  logic [$clog2(NUM_OUTPUT+1)-1:0]      out_deq_cnt,
  output logic [$clog2(DEPTH+1)-1:0]           count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         enqCnt;
  logic [CW-1:0]         deqEff;
  logic [CW-1:0]         deqCap;
  logic                  enqFire;
  logic [INPUT_SIZE-1:0] mem_q [DEPTH];

  // Ready only looks at registered occupancy, so a same-cycle dequeue earns no credit.
  assign in_rdy  = (CW'(DEPTH) - count_q) >= CW'(NUM_INPUT);
  assign count   = count_q;
  assign enqFire = in_rdy && !rst && !flush;
  assign deqCap  = (count_q < CW'(NUM_OUTPUT)) ? count_q : CW'(NUM_OUTPUT);

  always_comb begin
    enqCnt = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      enqCnt = enqCnt + CW'(in_vld[i]);
    end
    deqEff = CW'(out_deq_cnt);
    if (deqEff > deqCap) deqEff = deqCap;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rst || flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(deqEff);
      count_d = count_q - deqEff;
      if (enqFire) begin
        tail_d  = tail_q + PW'(enqCnt);
        count_d = count_d + enqCnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (enqFire) begin
      for (int i = 0; i < NUM_INPUT; i++) begin
        if (in_vld[i]) begin
          mem_q[tail_q + PW'(i)] <= in_data[i*INPUT_SIZE +: INPUT_SIZE];
        end
      end
    end
  end

  always_comb begin
    out_vld  = '0;
    out_data = '0;
    for (int k = 0; k < NUM_OUTPUT; k++) begin
      if (CW'(k) < count_q) begin
        out_vld[k] = 1'b1;
        out_data[k*INPUT_SIZE +: INPUT_SIZE] = mem_q[head_q + PW'(k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((in_vld & (in_vld + NUM_INPUT'(1))) == '0)
        else $error("compact_queue: non-contiguous in_vld %b", in_vld);
      assert (CW'(out_deq_cnt) <= deqCap)
        else $error("compact_queue: out_deq_cnt %0d exceeds valid lanes %0d", out_deq_cnt, deqCap);
    end
  end

endmodule

// File: tb/tb_compact_queue.sv
// Directed plus randomized bench for compact_queue, checked against a
// queue-based model of the occupancy and FIFO order.
module tb_compact_queue;

  localparam int NI    = 8;
  localparam int IS    = 4;
  localparam int NO    = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [NI-1:0]    in_vld;
  logic [NI*IS-1:0] in_data;
  logic             in_rdy;
  logic [NO-1:0]    out_vld;
  logic [NO*IS-1:0] out_data;
  logic [2:0]       out_deq_cnt;
  logic [4:0]       count;

  int checks   = 0;
  int failures = 0;
  logic [IS-1:0] model[$];

  compact_queue #(
    .NUM_INPUT(NI), .INPUT_SIZE(IS), .NUM_OUTPUT(NO), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_data(out_data),
    .out_deq_cnt(out_deq_cnt), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag);
    int n;
    logic [4:0]    expCount;
    logic          expRdy;
    logic          expVld;
    logic [IS-1:0] expData;
    n        = model.size();
    expCount = 5'(n);
    expRdy   = (DEPTH - n) >= NI;
    checks++;
    assert (count === expCount) else begin
      failures++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, count, expCount);
    end
    checks++;
    assert (in_rdy === expRdy) else begin
      failures++;
      $error("FAIL %s in_rdy observed=%b expected=%b", tag, in_rdy, expRdy);
    end
    for (int k = 0; k < NO; k++) begin
      expVld  = (k < n);
      expData = (k < n) ? model[k] : '0;
      checks++;
      assert (out_vld[k] === expVld) else begin
        failures++;
        $error("FAIL %s out_vld[%0d] observed=%b expected=%b", tag, k, out_vld[k], expVld);
      end
      checks++;
      assert (out_data[k*IS +: IS] === expData) else begin
        failures++;
        $error("FAIL %s out_data[%0d] observed=%h expected=%h", tag, k, out_data[k*IS +: IS], expData);
      end
    end
  endtask

  // One clock: drive at the falling edge, advance the model, check just after the rising edge.
  task automatic applyStimulus(input string tag, input int nEnq, input int nDeq,
                               input bit fl, input bit rs, input logic [NI*IS-1:0] dat);
    int  deqEff;
    bit  rdy;
    @(negedge clk);
    rst         = rs;
    flush       = fl;
    in_vld      = '0;
    for (int i = 0; i < nEnq; i++) in_vld[i] = 1'b1;
    in_data     = dat;
    out_deq_cnt = 3'(nDeq);
    rdy = (DEPTH - model.size()) >= NI;
    if (rs || fl) begin
      model.delete();
    end else begin
      deqEff = nDeq;
      if (deqEff > model.size()) deqEff = model.size();
      if (deqEff > NO) deqEff = NO;
      repeat (deqEff) void'(model.pop_front());
      if (rdy) for (int i = 0; i < nEnq; i++) model.push_back(dat[i*IS +: IS]);
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int nEnq;
    int nDeq;
    int maxDeq;
    rst         = 1'b1;
    flush       = 1'b0;
    in_vld      = '0;
    in_data     = '0;
    out_deq_cnt = '0;
    $display("[TB] compact_queue bench starting");

    applyStimulus("reset0", 0, 0, 0, 1, '0);
    applyStimulus("reset1", 0, 0, 0, 1, '0);
    applyStimulus("idle", 0, 0, 0, 0, '0);

    applyStimulus("enq3", 3, 0, 0, 0, 32'h0000_0CBA);
    applyStimulus("deq2", 0, 2, 0, 0, '0);

    applyStimulus("flushA", 0, 0, 1, 0, '0);
    applyStimulus("fill1", 8, 0, 0, 0, $urandom());
    applyStimulus("fill2", 8, 0, 0, 0, $urandom());
    applyStimulus("fullIgnored", 8, 0, 0, 0, $urandom());
    applyStimulus("deqTo12", 0, 4, 0, 0, '0);
    applyStimulus("deqTo8", 0, 4, 0, 0, '0);

    applyStimulus("enqDeqAt8", 8, 4, 0, 0, $urandom());

    applyStimulus("flushB", 0, 0, 1, 0, '0);
    applyStimulus("wrapPrime", 3, 0, 0, 0, $urandom());
    for (int c = 0; c < 10; c++) applyStimulus("wrap", 3, 3, 0, 0, $urandom());

    applyStimulus("flushC", 0, 0, 1, 0, '0);
    applyStimulus("enq5", 5, 0, 0, 0, $urandom());
    applyStimulus("flushPrio", 2, 1, 1, 0, $urandom());
    applyStimulus("postFlushEnq", 1, 0, 0, 0, $urandom());

    applyStimulus("midReset", 4, 1, 0, 1, $urandom());

    for (int c = 0; c < 300; c++) begin
      nEnq   = $urandom_range(0, NI);
      maxDeq = (model.size() < NO) ? model.size() : NO;
      nDeq   = $urandom_range(0, maxDeq);
      if ($urandom_range(0, 39) == 0)
        applyStimulus("randFlush", nEnq, nDeq, 1, 0, $urandom());
      else if ($urandom_range(0, 79) == 0)
        applyStimulus("randReset", nEnq, nDeq, 0, 1, $urandom());
      else
        applyStimulus("rand", nEnq, nDeq, 0, 0, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
